// File: rtl/ps2_scancode_fifo.sv
// PS/2 scancode front end: set-2 decoder (optional set-1 translation) feeding a
// small FIFO that the host drains one code per clear_keycode pulse.
module ps2_scancode_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter bit TRANSLATE  = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_error,
  input  logic                          reset_keyboard,
  input  logic                          clear_keycode,
  output logic                          irq,
  output logic [7:0]                    keycode,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [1:0]                    dbg_state_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} dec_state_e;

  dec_state_e    state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q;
  logic          push_req, do_push, do_pop;
  logic [7:0]    push_data;

  function automatic logic [7:0] xlat(input logic [7:0] b);
    case (b)
      8'h00: xlat = 8'hFF; 8'h01: xlat = 8'h43; 8'h03: xlat = 8'h3F; 8'h04: xlat = 8'h3D;
      8'h05: xlat = 8'h3B; 8'h06: xlat = 8'h3C; 8'h07: xlat = 8'h58; 8'h09: xlat = 8'h44;
      8'h0A: xlat = 8'h42; 8'h0B: xlat = 8'h40; 8'h0C: xlat = 8'h3E; 8'h0D: xlat = 8'h0F;
      8'h0E: xlat = 8'h29; 8'h11: xlat = 8'h38; 8'h12: xlat = 8'h2A; 8'h14: xlat = 8'h1D;
      8'h15: xlat = 8'h10; 8'h16: xlat = 8'h02; 8'h1A: xlat = 8'h2C; 8'h1B: xlat = 8'h1F;
      8'h1C: xlat = 8'h1E; 8'h1D: xlat = 8'h11; 8'h1E: xlat = 8'h03; 8'h21: xlat = 8'h2E;
      8'h22: xlat = 8'h2D; 8'h23: xlat = 8'h20; 8'h24: xlat = 8'h12; 8'h25: xlat = 8'h05;
      8'h26: xlat = 8'h04; 8'h29: xlat = 8'h39; 8'h2A: xlat = 8'h2F; 8'h2B: xlat = 8'h21;
      8'h2C: xlat = 8'h14; 8'h2D: xlat = 8'h13; 8'h2E: xlat = 8'h06; 8'h31: xlat = 8'h31;
      8'h32: xlat = 8'h30; 8'h33: xlat = 8'h23; 8'h34: xlat = 8'h22; 8'h35: xlat = 8'h15;
      8'h36: xlat = 8'h07; 8'h3A: xlat = 8'h32; 8'h3B: xlat = 8'h24; 8'h3C: xlat = 8'h16;
      8'h3D: xlat = 8'h08; 8'h3E: xlat = 8'h09; 8'h41: xlat = 8'h33; 8'h42: xlat = 8'h25;
      8'h43: xlat = 8'h17; 8'h44: xlat = 8'h18; 8'h45: xlat = 8'h0B; 8'h46: xlat = 8'h0A;
      8'h49: xlat = 8'h34; 8'h4A: xlat = 8'h35; 8'h4B: xlat = 8'h26; 8'h4C: xlat = 8'h27;
      8'h4D: xlat = 8'h19; 8'h4E: xlat = 8'h0C; 8'h52: xlat = 8'h28; 8'h54: xlat = 8'h1A;
      8'h55: xlat = 8'h0D; 8'h58: xlat = 8'h3A; 8'h59: xlat = 8'h36; 8'h5A: xlat = 8'h1C;
      8'h5B: xlat = 8'h1B; 8'h5D: xlat = 8'h2B; 8'h66: xlat = 8'h0E; 8'h69: xlat = 8'h4F;
      8'h6B: xlat = 8'h4B; 8'h6C: xlat = 8'h47; 8'h70: xlat = 8'h52; 8'h71: xlat = 8'h53;
      8'h72: xlat = 8'h50; 8'h73: xlat = 8'h4C; 8'h74: xlat = 8'h4D; 8'h75: xlat = 8'h48;
      8'h76: xlat = 8'h01; 8'h77: xlat = 8'h45; 8'h78: xlat = 8'h57; 8'h79: xlat = 8'h4E;
      8'h7A: xlat = 8'h51; 8'h7B: xlat = 8'h4A; 8'h7C: xlat = 8'h37; 8'h7D: xlat = 8'h49;
      8'h7E: xlat = 8'h46; 8'h83: xlat = 8'h41;
      default: xlat = 8'h00;
    endcase
  endfunction

  // rx_valid/rx_error are single-cycle strobes with no backpressure: a code that
  // cannot be stored is lost and recorded in the sticky overflow flag.
  always_comb begin
    state_d   = state_q;
    push_req  = 1'b0;
    push_data = 8'h00;
    if (reset_keyboard) begin
      state_d = IDLE;
    end else if (rx_error) begin
      push_req  = 1'b1;
      push_data = 8'hFF;
      state_d   = IDLE;
    end else if (rx_valid) begin
      if (!TRANSLATE) begin
        push_req  = 1'b1;
        push_data = rx_data;
        state_d   = IDLE;
      end else if (rx_data != 8'hFA) begin
        case (state_q)
          IDLE: begin
            if (rx_data == 8'hF0) begin
              state_d = BRK;
            end else if (rx_data == 8'hE0) begin
              push_req  = 1'b1;
              push_data = 8'hE0;
              state_d   = EXT;
            end else begin
              push_req  = 1'b1;
              push_data = (rx_data == 8'hE1) ? 8'hE1 : xlat(rx_data);
            end
          end
          EXT: begin
            if (rx_data == 8'hF0) begin
              state_d = EXT_BRK;
            end else begin
              push_req  = 1'b1;
              push_data = xlat(rx_data);
              state_d   = IDLE;
            end
          end
          default: begin
            push_req  = 1'b1;
            push_data = xlat(rx_data) | 8'h80;
            state_d   = IDLE;
          end
        endcase
      end
    end
  end

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_pop  = clear_keycode && (count_q != '0);
  assign do_push = push_req && ((count_q != CW'(FIFO_DEPTH)) || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (reset_keyboard) begin
        mem_q[0] <= 8'hAA;
        rd_ptr_q <= '0;
        wr_ptr_q <= PW'(1);
        count_q  <= CW'(1);
      end else begin
        if (do_push) begin
          mem_q[wr_ptr_q] <= push_data;
          wr_ptr_q        <= wr_ptr_q + PW'(1);
        end
        if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_d;
        if (push_req && !do_push) overflow_q <= 1'b1;
      end
    end
  end

  assign irq         = (count_q != '0);
  assign keycode     = irq ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Bench for ps2_scancode_fifo: translating and raw instances share one input set
// and are checked against queue-based reference models, vector tables and sequences.
module tb_ps2_scancode_fifo;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, rx_valid, rx_error, reset_keyboard, clear_keycode;
  logic [7:0]    rx_data;
  logic          t_irq, r_irq, t_ovf, r_ovf;
  logic [7:0]    t_key, r_key;
  logic [CW-1:0] t_cnt, r_cnt;
  logic [1:0]    t_st, r_st;

  ps2_scancode_fifo #(.FIFO_DEPTH(DEPTH), .TRANSLATE(1'b1)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_error(rx_error), .reset_keyboard(reset_keyboard), .clear_keycode(clear_keycode),
    .irq(t_irq), .keycode(t_key), .fifo_count(t_cnt), .overflow(t_ovf), .dbg_state_o(t_st));

  ps2_scancode_fifo #(.FIFO_DEPTH(DEPTH), .TRANSLATE(1'b0)) dut_raw (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_error(rx_error), .reset_keyboard(reset_keyboard), .clear_keycode(clear_keycode),
    .irq(r_irq), .keycode(r_key), .fifo_count(r_cnt), .overflow(r_ovf), .dbg_state_o(r_st));

  int errors = 0;
  int checks = 0;

  logic [7:0] mq[$];
  logic [7:0] rq[$];
  bit         m_ovf, rm_ovf, m_brk, m_ext;
  logic [7:0] pool [8];

  typedef struct {
    bit         rst, rk, err, v;
    logic [7:0] d;
    bit         clr;
    int         cnt;
    logic [7:0] key;
    bit         ovf;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xl(input logic [7:0] b);
    case (b)
      8'h1C: xl = 8'h1E; 8'h76: xl = 8'h01; 8'h5A: xl = 8'h1C; 8'h83: xl = 8'h41;
      8'h29: xl = 8'h39; 8'h00: xl = 8'hFF; 8'h16: xl = 8'h02; 8'h75: xl = 8'h48;
      default: xl = 8'h00;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit rk, input bit err, input bit v,
                            input logic [7:0] d, input bit clr);
    bit pp;
    logic [7:0] pd;
    if (rst) begin
      mq.delete(); rq.delete();
      m_ovf = 0; rm_ovf = 0; m_brk = 0; m_ext = 0;
      return;
    end
    if (rk) begin
      mq.delete(); rq.delete();
      mq.push_back(8'hAA); rq.push_back(8'hAA);
      m_brk = 0; m_ext = 0;
      return;
    end
    pp = 0; pd = 8'h00;
    if (err) begin
      pp = 1; pd = 8'hFF; m_brk = 0; m_ext = 0;
    end else if (v && d != 8'hFA) begin
      if (m_brk) begin
        pp = 1; pd = xl(d) | 8'h80; m_brk = 0; m_ext = 0;
      end else if (d == 8'hF0) begin
        m_brk = 1;
      end else if (m_ext) begin
        pp = 1; pd = xl(d); m_ext = 0;
      end else if (d == 8'hE0) begin
        pp = 1; pd = 8'hE0; m_ext = 1;
      end else begin
        pp = 1; pd = (d == 8'hE1) ? 8'hE1 : xl(d);
      end
    end
    if (clr && mq.size() > 0) void'(mq.pop_front());
    if (pp) begin
      if (mq.size() < DEPTH) mq.push_back(pd);
      else m_ovf = 1;
    end
    if (clr && rq.size() > 0) void'(rq.pop_front());
    if (err || v) begin
      if (rq.size() < DEPTH) rq.push_back(err ? 8'hFF : d);
      else rm_ovf = 1;
    end
  endtask

  task automatic check_model();
    chk("t_count", t_cnt, mq.size());
    chk("t_irq", t_irq, mq.size() != 0);
    chk("t_keycode", t_key, (mq.size() != 0) ? mq[0] : 8'h00);
    chk("t_overflow", t_ovf, m_ovf);
    chk("r_count", r_cnt, rq.size());
    chk("r_irq", r_irq, rq.size() != 0);
    chk("r_keycode", r_key, (rq.size() != 0) ? rq[0] : 8'h00);
    chk("r_overflow", r_ovf, rm_ovf);
  endtask

  task automatic step(input bit rst, input bit rk, input bit err, input bit v,
                      input logic [7:0] d, input bit clr);
    reset = rst; reset_keyboard = rk; rx_error = err;
    rx_valid = v; rx_data = v ? d : 8'h00; clear_keycode = clr;
    @(posedge clock);
    #1;
    model_step(rst, rk, err, v, d, clr);
    check_model();
  endtask

  task automatic add(input bit rst, input bit rk, input bit err, input bit v,
                     input logic [7:0] d, input bit clr, input int cnt,
                     input logic [7:0] key, input bit ovf);
    vec_t e;
    e.rst = rst; e.rk = rk; e.err = err; e.v = v; e.d = d; e.clr = clr;
    e.cnt = cnt; e.key = key; e.ovf = ovf;
    tbl.push_back(e);
  endtask

  initial begin
    logic [7:0] b;
    bit         lo_clr;
    pool[0] = 8'h1C; pool[1] = 8'h76; pool[2] = 8'h5A; pool[3] = 8'h83;
    pool[4] = 8'h29; pool[5] = 8'h00; pool[6] = 8'h16; pool[7] = 8'h75;
    reset = 1; rx_valid = 0; rx_data = 0; rx_error = 0; reset_keyboard = 0; clear_keycode = 0;

    //   rst rk err v  data  clr  cnt key   ovf
    add(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
    add(0, 0, 0, 1, 8'h1C, 0, 1, 8'h1E, 0);
    add(0, 0, 0, 1, 8'hF0, 0, 1, 8'h1E, 0);
    add(0, 0, 0, 1, 8'h1C, 0, 2, 8'h1E, 0);
    add(0, 0, 0, 0, 8'h00, 1, 1, 8'h9E, 0);
    add(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0);
    add(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0);
    add(0, 0, 0, 1, 8'hE0, 0, 1, 8'hE0, 0);
    add(0, 0, 0, 1, 8'hF0, 0, 1, 8'hE0, 0);
    add(0, 0, 0, 1, 8'h75, 0, 2, 8'hE0, 0);
    add(0, 0, 0, 0, 8'h00, 1, 1, 8'hC8, 0);
    add(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0);
    add(0, 0, 0, 1, 8'hF0, 0, 0, 8'h00, 0);
    add(0, 0, 1, 0, 8'h00, 0, 1, 8'hFF, 0);
    add(0, 0, 0, 1, 8'h1C, 0, 2, 8'hFF, 0);
    add(0, 0, 0, 0, 8'h00, 1, 1, 8'h1E, 0);
    add(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0);
    add(0, 0, 0, 1, 8'hFA, 0, 0, 8'h00, 0);
    add(0, 0, 0, 1, 8'h76, 0, 1, 8'h01, 0);
    add(0, 0, 0, 1, 8'h5A, 0, 2, 8'h01, 0);
    add(0, 0, 0, 1, 8'h83, 0, 3, 8'h01, 0);
    add(0, 1, 0, 1, 8'h1C, 0, 1, 8'hAA, 0);
    add(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0);
    add(0, 0, 0, 1, 8'h29, 0, 1, 8'h39, 0);
    add(0, 0, 0, 1, 8'h00, 0, 2, 8'h39, 0);
    add(0, 0, 0, 0, 8'h00, 1, 1, 8'hFF, 0);
    add(0, 0, 1, 1, 8'h1C, 1, 1, 8'hFF, 0);
    add(0, 0, 0, 1, 8'h5A, 1, 1, 8'h1C, 0);
    add(0, 0, 0, 1, 8'hF0, 1, 0, 8'h00, 0);
    add(1, 0, 0, 1, 8'h1C, 0, 0, 8'h00, 0);
    add(0, 0, 0, 1, 8'h1C, 0, 1, 8'h1E, 0);
    add(0, 0, 0, 1, 8'hE0, 1, 1, 8'hE0, 0);
    add(0, 0, 0, 1, 8'hF0, 0, 1, 8'hE0, 0);
    add(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
    add(0, 0, 0, 1, 8'h76, 0, 1, 8'h01, 0);
    add(0, 0, 0, 1, 8'hF0, 0, 1, 8'h01, 0);
    add(0, 1, 0, 0, 8'h00, 0, 1, 8'hAA, 0);
    add(0, 0, 0, 1, 8'h1C, 1, 1, 8'h1E, 0);

    step(1, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].rk, tbl[i].err, tbl[i].v, tbl[i].d, tbl[i].clr);
      chk($sformatf("vec%0d_count", i), t_cnt, tbl[i].cnt);
      chk($sformatf("vec%0d_key", i), t_key, tbl[i].key);
      chk($sformatf("vec%0d_irq", i), t_irq, tbl[i].cnt != 0);
      chk($sformatf("vec%0d_ovf", i), t_ovf, tbl[i].ovf);
    end

    // Overfill with 16: nine pushes, eight stored, overflow sticky.
    step(1, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 1, 8'h16, 0);
    chk("ovf_fill_count", t_cnt, DEPTH);
    chk("ovf_fill_flag", t_ovf, 1);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("ovf_entry%0d", i), t_key, 8'h02);
      step(0, 0, 0, 0, 8'h00, 1);
    end
    chk("ovf_drained_count", t_cnt, 0);
    chk("ovf_still_sticky", t_ovf, 1);
    step(0, 1, 0, 0, 8'h00, 0);
    chk("ovf_after_kbreset", t_ovf, 1);
    chk("kbreset_key", t_key, 8'hAA);
    step(1, 0, 0, 0, 8'h00, 0);
    chk("ovf_cleared_by_reset", t_ovf, 0);

    // Full FIFO with simultaneous pop and push: push is accepted.
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 8'h1C, 0);
    step(0, 0, 0, 1, 8'h76, 1);
    chk("full_pushpop_count", t_cnt, DEPTH);
    chk("full_pushpop_ovf", t_ovf, 0);
    for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 0, 0, 8'h00, 1);
    chk("full_pushpop_tail", t_key, 8'h01);

    // Raw passthrough instance.
    step(1, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 1, 8'hFA, 0);
    step(0, 0, 0, 1, 8'hF0, 0);
    step(0, 0, 0, 1, 8'h1C, 0);
    chk("raw_count3", r_cnt, 3);
    chk("raw_head_fa", r_key, 8'hFA);
    step(0, 0, 0, 1, 8'h16, 1);
    chk("raw_pushpop_count", r_cnt, 3);
    chk("raw_head_f0", r_key, 8'hF0);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("raw_head_1c", r_key, 8'h1C);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("raw_head_16", r_key, 8'h16);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("raw_empty_irq", r_irq, 0);

    // Randomized traffic, alternating drain-heavy and fill-heavy phases.
    step(1, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3000; i++) begin
      lo_clr = ((i / 300) % 2) == 1;
      if (m_brk) b = ($urandom_range(0, 8) == 8) ? 8'hFA : pool[$urandom_range(0, 7)];
      else begin
        case ($urandom_range(0, m_ext ? 9 : 11))
          8:       b = 8'hFA;
          9:       b = 8'hF0;
          10:      b = 8'hE0;
          11:      b = 8'hE1;
          default: b = pool[$urandom_range(0, 7)];
        endcase
      end
      step($urandom_range(0, 399) == 0, $urandom_range(0, 79) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1, b,
           $urandom_range(0, 9) < (lo_clr ? 1 : 6));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_scancode_fifo.md
PS2_SCANCODE_FIFO -- requirements
Module: ps2_scancode_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of buffered output codes; power of two, 2..64.
REQ-002 Parameter TRANSLATE, default 1: 1 = set-2 to set-1 translation; 0 = raw passthrough.
REQ-003 clock  input  1  single clock; all logic on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_valid  input  1  one-cycle pulse, rx_data holds a received PS/2 byte.
REQ-006 rx_data  input  8  received byte, valid only while rx_valid=1.
REQ-007 rx_error  input  1  one-cycle pulse, parity/framing/timeout error from the shift register.
REQ-008 reset_keyboard  input  1  host keyboard-reset request.
REQ-009 clear_keycode  input  1  host acknowledge; pops the head entry.
REQ-010 irq  output  1  high while the FIFO is non-empty.
REQ-011 keycode  output  8  FIFO head entry; 8'h00 when empty.
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of stored entries.
REQ-013 overflow  output  1  sticky; set when a push is dropped because the FIFO is full.

Function
REQ-014 Input priority per cycle: reset > reset_keyboard > rx_error > rx_valid; lower-priority inputs in the same cycle are discarded.
REQ-015 reset_keyboard: flush the FIFO, push 8'hAA, return the decoder to IDLE; irq=1 and keycode=AA on the next cycle.
REQ-016 rx_error: push 8'hFF; decoder returns to IDLE.
REQ-017 The decoder FSM (TRANSLATE=1) has states IDLE, BRK, EXT and EXT_BRK.
REQ-018 In any state, byte FA (ACK) is dropped with no push and no state change.
REQ-019 IDLE: F0 -> BRK, no push; E0 -> push E0, go to EXT; E1 -> push E1, stay in IDLE; any other byte -> push xlat(byte), stay in IDLE.
REQ-020 BRK: any byte -> push xlat(byte)|8'h80, go to IDLE.
REQ-021 EXT: F0 -> EXT_BRK, no push; any other byte -> push xlat(byte), go to IDLE.
REQ-022 EXT_BRK: any byte -> push xlat(byte)|8'h80, go to IDLE.
REQ-023 xlat is the team's standard set-2 to set-1 table; the bench checks these entries: 1C->1E, 76->01, 5A->1C, 83->41, 29->39, 00->FF.
REQ-024 TRANSLATE=0: every rx_valid byte, FA included, is pushed unchanged; the FSM is held in IDLE.
REQ-025 Latency: a push at cycle N is visible on keycode/irq at cycle N+1 when the FIFO was empty.
REQ-026 clear_keycode pops exactly one entry per asserted cycle; it is ignored when the FIFO is empty.
REQ-027 Simultaneous push and pop: both take effect and fifo_count is unchanged.
REQ-028 Push when full: the entry is dropped, overflow is set, and the FIFO contents are unchanged; a pop in the same cycle frees a slot first, so that push succeeds.
REQ-029 Read and write pointers wrap modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH.
REQ-030 A break prefix followed by rx_error: FF is pushed and the pending break is discarded.

Reset
REQ-031 While reset is high at a clock edge: FIFO emptied, pointers=0, fifo_count=0, irq=0, keycode=00, overflow=0, FSM=IDLE.
REQ-032 Reset takes effect mid-sequence (e.g. in BRK or EXT_BRK) with no partial push.
REQ-033 overflow clears only on reset.

Verification
REQ-034 Stimulus rx 1C, then F0, 1C (TRANSLATE=1) -> entries 1E, 9E; irq falls after two clear_keycode pulses.
REQ-035 Stimulus E0, F0, 75 -> entries E0, C8; the F0 byte produces no entry.
REQ-036 Stimulus FIFO_DEPTH+1 bytes 16 with no clears -> fifo_count=FIFO_DEPTH, overflow=1, all entries 02.
REQ-037 Stimulus reset_keyboard and rx_valid(1C) in the same cycle, with 3 entries queued -> FIFO holds only AA, fifo_count=1.
REQ-038 Stimulus F0, then rx_error -> single entry FF; the next byte 1C yields 1E (break discarded).
REQ-039 Stimulus TRANSLATE=0, bytes FA, F0, 1C -> entries FA, F0, 1C unchanged; a push and a pop in the same cycle leave fifo_count constant.
